// File: rtl/asa_types.sv
// Shared message formats and scheduler state encoding for the ASA request path.
// A request scheduler serialises many tile requesters onto one ASA instance.
package asa_types;

    localparam int ASA_XY_SZ  = 3;
    localparam int ASA_SRC_W  = 2 * ASA_XY_SZ;
    localparam int ASA_CNT_W  = 13;
    localparam int ASA_HDR_W  = 32;

    typedef struct packed {
        logic [3:0]           opcode;
        logic [ASA_SRC_W-1:0] src;
        logic [31:0]          addr;
        logic [31:0]          data;
    } ASAReqMsg;

    typedef struct packed {
        logic [3:0]           status;
        logic [ASA_SRC_W-1:0] src;
        logic [31:0]          data;
    } ASARespMsg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DELIVER
    } ASA_SCHED_STATE_T;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ASA_CNT_W-1:0] sat_inc(input logic [ASA_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/asa_rr_arb.sv
// Round-robin picker: one-hot grant to the first requester found after 'last'.
// Pure combinational; the caller owns the last-grant register.
module asa_rr_arb #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant
);

    logic [IW-1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((32'(last) + 32'(k)) % 32'(N));
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/asa_req_sched.sv
// Shares one ASA instance among N_REQ requesters, one outstanding request at a time,
// with a response timeout and a held delivery stage toward the encoder.
module asa_req_sched
    import asa_types::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int XY_SZ       = 3,
    localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk_ctrl,
    input  logic                        clk_ctrl_rst_low,
    input  logic [N_REQ-1:0]            req_val,
    output logic [N_REQ-1:0]            req_rdy,
    input  ASAReqMsg [N_REQ-1:0]        req_msg,
    input  logic [N_REQ-1:0][31:0]      req_hdr,
    output logic                        asa_req_val,
    input  logic                        asa_req_rdy,
    output ASAReqMsg                    asa_req_msg,
    input  logic                        asa_resp_val,
    output logic                        asa_resp_rdy,
    input  ASARespMsg                   asa_resp_msg,
    output logic                        resp_val,
    input  logic                        resp_rdy,
    output ASARespMsg                   resp_msg,
    output logic [31:0]                 resp_hdr,
    output logic [IDX_W-1:0]            resp_idx,
    output logic                        timeout_err,
    output logic                        busy
);

    if (XY_SZ != ASA_XY_SZ) begin : g_xy_chk
        $error("asa_req_sched: XY_SZ must match asa_types::ASA_XY_SZ");
    end
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > (1 << ASA_CNT_W)) begin : g_to_chk
        $error("asa_req_sched: TIMEOUT_CYC out of counter range");
    end

    localparam logic [ASA_CNT_W-1:0] TO_LAST = ASA_CNT_W'(TIMEOUT_CYC - 1);

    ASA_SCHED_STATE_T      state_q, state_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [ASA_CNT_W-1:0]  cnt_q, cnt_d;
    ASAReqMsg              req_msg_q, req_msg_d;
    logic [31:0]           hdr_q, hdr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    ASARespMsg             resp_msg_q, resp_msg_d;
    logic                  busy_q, busy_d;
    logic                  asa_req_val_q, asa_req_val_d;
    logic                  asa_resp_rdy_q, asa_resp_rdy_d;
    logic                  resp_val_q, resp_val_d;
    logic                  timeout_q, timeout_d;

    logic [N_REQ-1:0]      grant;
    logic [IDX_W-1:0]      grant_idx;

    asa_rr_arb #(
        .N(N_REQ)
    ) u_arb (
        .req   (req_val),
        .last  (last_q),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    // Accept is offered only while idle; gating with reset keeps it low during reset
    // even though the arbiter sees live req_val.
    assign req_rdy = (state_q == ST_IDLE && clk_ctrl_rst_low) ? grant : '0;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        req_msg_d  = req_msg_q;
        hdr_d      = hdr_q;
        idx_d      = idx_q;
        resp_msg_d = resp_msg_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_val) begin
                    state_d   = ST_ISSUE;
                    last_d    = grant_idx;
                    idx_d     = grant_idx;
                    req_msg_d = req_msg[grant_idx];
                    hdr_d     = req_hdr[grant_idx];
                end
            end
            ST_ISSUE: begin
                if (asa_req_rdy) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                // A response in the final counted cycle still beats the timeout.
                if (asa_resp_val) begin
                    resp_msg_d = asa_resp_msg;
                    state_d    = ST_DELIVER;
                end else if (cnt_q >= TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_DELIVER: begin
                if (resp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d         = (state_d != ST_IDLE);
        asa_req_val_d  = (state_d == ST_ISSUE);
        asa_resp_rdy_d = (state_d == ST_WAIT);
        resp_val_d     = (state_d == ST_DELIVER);
    end

    always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
        if (!clk_ctrl_rst_low) begin
            state_q        <= ST_IDLE;
            last_q         <= IDX_W'(N_REQ - 1);
            cnt_q          <= '0;
            req_msg_q      <= '0;
            hdr_q          <= '0;
            idx_q          <= '0;
            resp_msg_q     <= '0;
            busy_q         <= 1'b0;
            asa_req_val_q  <= 1'b0;
            asa_resp_rdy_q <= 1'b0;
            resp_val_q     <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
            req_msg_q      <= req_msg_d;
            hdr_q          <= hdr_d;
            idx_q          <= idx_d;
            resp_msg_q     <= resp_msg_d;
            busy_q         <= busy_d;
            asa_req_val_q  <= asa_req_val_d;
            asa_resp_rdy_q <= asa_resp_rdy_d;
            resp_val_q     <= resp_val_d;
            timeout_q      <= timeout_d;
        end
    end

    assign asa_req_val  = asa_req_val_q;
    assign asa_req_msg  = req_msg_q;
    assign asa_resp_rdy = asa_resp_rdy_q;
    assign resp_val     = resp_val_q;
    assign resp_msg     = resp_msg_q;
    assign resp_hdr     = hdr_q;
    assign resp_idx     = idx_q;
    assign timeout_err  = timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_asa_req_sched.sv
// Directed bench for asa_req_sched: a driver plays requesters and the ASA, while
// negedge monitors score grants and delivered responses against queued expectations.
module tb_asa_req_sched;
    import asa_types::*;

    localparam int TO = 16;

    typedef struct packed {
        ASARespMsg   msg;
        logic [31:0] hdr;
        logic [1:0]  idx;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           req_val;
    logic [3:0]           req_rdy;
    ASAReqMsg [3:0]       req_msg;
    logic [3:0][31:0]     req_hdr;
    logic                 asa_req_val;
    logic                 asa_req_rdy;
    ASAReqMsg             asa_req_msg;
    logic                 asa_resp_val;
    logic                 asa_resp_rdy;
    ASARespMsg            asa_resp_msg;
    logic                 resp_val;
    logic                 resp_rdy;
    ASARespMsg            resp_msg;
    logic [31:0]          resp_hdr;
    logic [1:0]           resp_idx;
    logic                 timeout_err;
    logic                 busy;

    ASAReqMsg             msg_tab [4];
    logic [31:0]          hdr_tab [4];
    exp_t                 exp_q [$];
    int                   grant_q [$];
    int                   n_checks = 0;
    int                   n_fail = 0;
    int                   timeout_cnt = 0;
    int                   resp_cnt = 0;
    exp_t                 mon_e;
    int                   mon_g;
    logic [3:0]           mon_oh;

    asa_req_sched #(
        .N_REQ(4),
        .TIMEOUT_CYC(TO),
        .XY_SZ(3)
    ) dut (
        .clk_ctrl         (clk),
        .clk_ctrl_rst_low (rst_n),
        .req_val          (req_val),
        .req_rdy          (req_rdy),
        .req_msg          (req_msg),
        .req_hdr          (req_hdr),
        .asa_req_val      (asa_req_val),
        .asa_req_rdy      (asa_req_rdy),
        .asa_req_msg      (asa_req_msg),
        .asa_resp_val     (asa_resp_val),
        .asa_resp_rdy     (asa_resp_rdy),
        .asa_resp_msg     (asa_resp_msg),
        .resp_val         (resp_val),
        .resp_rdy         (resp_rdy),
        .resp_msg         (resp_msg),
        .resp_hdr         (resp_hdr),
        .resp_idx         (resp_idx),
        .timeout_err      (timeout_err),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ASARespMsg mk_resp(input int n);
        ASARespMsg r;
        r.status = 4'(n);
        r.src    = 6'(n * 5);
        r.data   = 32'hBEEF_0000 + 32'(n);
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        #1;
        check({tag, "_ctrl"}, {req_rdy, asa_req_val, asa_resp_rdy, resp_val, timeout_err, busy, resp_idx}, '0);
        check({tag, "_data"}, {asa_req_msg, resp_msg, resp_hdr}, '0);
    endtask

    // Monitors: every grant and every accepted response must match the next expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (|req_rdy) begin
                if (grant_q.size() == 0) begin
                    check("unexpected_grant", 256'(req_rdy), '0);
                end else begin
                    mon_g  = grant_q.pop_front();
                    mon_oh = 4'b0001 << mon_g;
                    check("grant_onehot", 256'(req_rdy), 256'(mon_oh));
                end
            end
            if (resp_val && resp_rdy) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 256'(resp_val), '0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_msg", 256'(resp_msg), 256'(mon_e.msg));
                    check("resp_hdr", 256'(resp_hdr), 256'(mon_e.hdr));
                    check("resp_idx", 256'(resp_idx), 256'(mon_e.idx));
                end
            end
            if (timeout_err) begin
                timeout_cnt++;
            end
        end
    end

    // resp_wait >= 0: response that many cycles after WAIT entry; -1: let it time out;
    // -2: pulse reset while waiting.
    task automatic do_txn(input logic [3:0] rv, input int exp_idx, input bit hold,
                          input int rdy_wait, input int resp_wait, input int dlv_wait,
                          input ASARespMsg rmsg);
        int   waited;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            req_msg[i] = msg_tab[i];
            req_hdr[i] = hdr_tab[i];
        end
        grant_q.push_back(exp_idx);
        if (resp_wait >= 0) begin
            e.msg = rmsg;
            e.hdr = hdr_tab[exp_idx];
            e.idx = 2'(exp_idx);
            exp_q.push_back(e);
        end
        req_val = rv;
        #1;
        waited = 0;
        while (req_rdy == 4'b0000) begin
            if (waited == 8) begin
                n_fail++;
                $display("FAIL grant_wait: req_rdy=0x%0h after %0d cycles, expected grant %0d", req_rdy, waited, exp_idx);
                $fatal(1, "no grant");
            end
            tick();
            waited++;
        end
        check("asa_req_val_at_grant", 256'(asa_req_val), 256'(0));

        tick();
        if (!hold) req_val = 4'b0000;
        req_msg[exp_idx] = ~msg_tab[exp_idx];
        req_hdr[exp_idx] = ~hdr_tab[exp_idx];
        for (int k = 0; k <= rdy_wait; k++) begin
            if (k > 0) tick();
            asa_req_rdy = (k == rdy_wait);
            if (!hold) req_val = (k < rdy_wait) ? 4'b1111 : 4'b0000;
            #1;
            check("asa_req_val_issue", 256'(asa_req_val), 256'(1));
            check("asa_req_msg_issue", 256'(asa_req_msg), 256'(msg_tab[exp_idx]));
            check("req_rdy_issue", 256'(req_rdy), '0);
        end

        tick();
        check("asa_resp_rdy_wait", 256'(asa_resp_rdy), 256'(1));
        check("asa_req_val_wait", 256'(asa_req_val), 256'(0));
        if (resp_wait == -1) begin
            for (int k = 0; k < TO; k++) begin
                if (k > 0) tick();
                check("timeout_early", 256'(timeout_err), '0);
                check("busy_wait", 256'(busy), 256'(1));
            end
            tick();
            check("timeout_pulse", 256'(timeout_err), 256'(1));
            check("busy_after_timeout", 256'(busy), '0);
            tick();
            check("timeout_single", 256'(timeout_err), '0);
        end else if (resp_wait == -2) begin
            tick();
            tick();
            req_val = 4'b1111;
            rst_n   = 1'b0;
            check_reset_outputs("reset_in_wait");
            tick();
            tick();
            req_val = 4'b0000;
            rst_n   = 1'b1;
            tick();
            check("busy_after_reset", 256'(busy), '0);
        end else begin
            for (int k = 0; k <= resp_wait; k++) begin
                if (k > 0) tick();
                asa_resp_val = (k == resp_wait);
                asa_resp_msg = (k == resp_wait) ? rmsg : ~rmsg;
                check("asa_resp_rdy_hold", 256'(asa_resp_rdy), 256'(1));
                check("resp_val_early", 256'(resp_val), '0);
            end
            tick();
            asa_resp_val = 1'b0;
            asa_resp_msg = '0;
            check("resp_val_at_r1", 256'(resp_val), 256'(1));
            check("no_timeout_on_resp", 256'(timeout_err), '0);
            check("asa_resp_rdy_deliver", 256'(asa_resp_rdy), '0);
            for (int k = 0; k <= dlv_wait; k++) begin
                if (k > 0) tick();
                resp_rdy = (k == dlv_wait);
                if (!hold) req_val = (k < dlv_wait) ? 4'b1111 : 4'b0000;
                #1;
                check("resp_val_hold", 256'(resp_val), 256'(1));
                check("resp_msg_hold", 256'(resp_msg), 256'(rmsg));
                check("resp_hdr_hold", 256'(resp_hdr), 256'(hdr_tab[exp_idx]));
                check("resp_idx_hold", 256'(resp_idx), 256'(exp_idx));
                check("req_rdy_deliver", 256'(req_rdy), '0);
            end
            tick();
            check("busy_after_deliver", 256'(busy), '0);
            check("resp_val_after_deliver", 256'(resp_val), '0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            msg_tab[i] = {4'(i + 3), 6'(9 * i + 5), 32'h1000_0000 + 32'(i * 16), 32'hC0DE_0000 + 32'(i)};
            hdr_tab[i] = 32'hA5A5_0000 | 32'(i * 257 + 1);
            req_msg[i] = msg_tab[i];
            req_hdr[i] = hdr_tab[i];
        end
        rst_n        = 1'b0;
        req_val      = 4'b1111;
        asa_req_rdy  = 1'b1;
        asa_resp_val = 1'b0;
        asa_resp_msg = '0;
        resp_rdy     = 1'b1;
        #12;
        check_reset_outputs("reset_initial");
        tick();
        req_val = 4'b0000;
        rst_n   = 1'b1;
        tick();

        // Lone requester 2, ASA ready at once, response 5 cycles into WAIT.
        do_txn(4'b0100, 2, 1'b0, 0, 5, 0, mk_resp(1));

        // Fresh reset, then all four held: round robin from index 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_txn(4'b1111, 0, 1'b1, 0, 1, 0, mk_resp(2));
        do_txn(4'b1111, 1, 1'b1, 0, 2, 0, mk_resp(3));
        do_txn(4'b1111, 2, 1'b1, 0, 0, 0, mk_resp(4));
        do_txn(4'b1111, 3, 1'b0, 0, 3, 0, mk_resp(5));

        // ASA back-pressure for 10 cycles.
        do_txn(4'b0001, 0, 1'b0, 10, 2, 0, mk_resp(6));

        // Stray ASA response while idle must be refused.
        asa_resp_val = 1'b1;
        asa_resp_msg = mk_resp(99);
        tick();
        check("stray_resp_rdy", 256'(asa_resp_rdy), '0);
        check("stray_resp_busy", 256'(busy), '0);
        tick();
        check("stray_resp_val", 256'(resp_val), '0);
        asa_resp_val = 1'b0;
        asa_resp_msg = '0;

        // No response at all: timeout.
        do_txn(4'b0010, 1, 1'b0, 0, -1, 0, mk_resp(7));

        // Encoder back-pressure for 7 cycles.
        do_txn(4'b1000, 3, 1'b0, 0, 1, 7, mk_resp(8));

        // Response lands in the very cycle the timeout would fire.
        do_txn(4'b0101, 0, 1'b0, 0, TO - 1, 0, mk_resp(9));

        // Search starts after last grant (0), so 3 beats a wrapped 0.
        do_txn(4'b1001, 3, 1'b0, 0, 4, 1, mk_resp(10));

        // Reset while waiting, then the next request is served from index 0.
        do_txn(4'b0010, 1, 1'b0, 0, -2, 0, mk_resp(11));
        do_txn(4'b1111, 0, 1'b0, 1, 3, 2, mk_resp(12));

        tick();
        check("grant_queue_drained", 256'(grant_q.size()), '0);
        check("resp_queue_drained", 256'(exp_q.size()), '0);
        check("timeout_count", 256'(timeout_cnt), 256'(1));
        check("resp_count", 256'(resp_cnt), 256'(10));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
